// File: rtl/morse_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : morse_tx_sequencer
// Description : Character-level Morse key sequencer. Accepts one ASCII
//               character per handshake and drives the lookup select bus.
//               It then shifts the returned unit pattern onto the key line at
//               UNIT_CYCLES clocks per unit and appends GAP_UNITS low units.
//               Optional macro MORSE_ERR_EN adds the char_err pulse output
//               and a saturating err_count_q register.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_tx_sequencer #(
  parameter int UNIT_CYCLES = 4,
  parameter int GAP_UNITS   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [6:0]  lut_sel,
  input  logic [4:0]  lut_len,
  input  logic [20:0] lut_pattern,
  output logic        morse_out,
  output logic        busy
`ifdef MORSE_ERR_EN
  ,
  output logic        char_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [23:0] C_UNIT_RELOAD = 24'(UNIT_CYCLES - 1);
  localparam logic [3:0]  C_GAP_LAST    = (GAP_UNITS > 0) ? 4'(GAP_UNITS - 1) : 4'd0;
  localparam logic        C_HAS_GAP     = (GAP_UNITS > 0);
  localparam logic [4:0]  C_MAX_LEN     = 5'd21;

  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [4:0]  idx_q,   idx_d;
  logic [3:0]  gap_q,   gap_d;
  logic [20:0] shift_q, shift_d;
  logic        morse_q, morse_d;
  logic [6:0]  sel_q,   sel_d;
  logic [4:0]  w_len_clamped;

  // Lookups may report more units than the pattern can hold; cap at 21.
  assign w_len_clamped = (lut_len > C_MAX_LEN) ? C_MAX_LEN : lut_len;

  // Next-state and datapath decisions for the character sequencing FSM
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    morse_d = morse_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        morse_d = 1'b0;
        if (char_valid) begin
          sel_d   = char_in;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_d = lut_pattern;
        if (w_len_clamped == 5'd0) begin
          // Unsupported character: drop it with no key activity and no gap.
          state_d = ST_IDLE;
        end else begin
          idx_d   = w_len_clamped - 5'd1;
          timer_d = C_UNIT_RELOAD;
          morse_d = lut_pattern[w_len_clamped - 5'd1];
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (timer_q == 24'd0) begin
          if (idx_q == 5'd0) begin
            morse_d = 1'b0;
            if (C_HAS_GAP) begin
              timer_d = C_UNIT_RELOAD;
              gap_d   = C_GAP_LAST;
              state_d = ST_GAP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q - 5'd1;
            timer_d = C_UNIT_RELOAD;
            morse_d = shift_q[idx_q - 5'd1];
          end
        end else begin
          timer_d = timer_q - 24'd1;
        end
      end
      ST_GAP: begin
        morse_d = 1'b0;
        if (timer_q == 24'd0) begin
          if (gap_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d   = gap_q - 4'd1;
            timer_d = C_UNIT_RELOAD;
          end
        end else begin
          timer_d = timer_q - 24'd1;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= 24'd0;
      idx_q   <= 5'd0;
      gap_q   <= 4'd0;
      shift_q <= 21'd0;
      morse_q <= 1'b0;
      sel_q   <= 7'h00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      morse_q <= morse_d;
      sel_q   <= sel_d;
    end
  end

`ifdef MORSE_ERR_EN
  logic       char_err_q;
  logic [4:0] err_count_q;
  logic       w_unsupported;

  assign w_unsupported = (state_q == ST_LOAD) && (w_len_clamped == 5'd0);

  // Flag and count characters the lookup cannot encode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_err_q  <= 1'b0;
      err_count_q <= 5'd0;
    end else begin
      char_err_q <= w_unsupported;
      if (w_unsupported && (err_count_q != 5'd31)) begin
        err_count_q <= err_count_q + 5'd1;
      end
    end
  end

  assign char_err = char_err_q;
`endif

  assign char_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign lut_sel    = sel_q;
  assign morse_out  = morse_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_tx_sequencer
// Description : Scoreboard bench for morse_tx_sequencer. Two instances run
//               side by side (UNIT_CYCLES=4/GAP_UNITS=2 and 1/0). A driver
//               per instance issues characters and pushes the per-cycle
//               expected outputs; a monitor pops and compares them.
//               Honours MORSE_ERR_EN for char_err and err_count_q.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_tx_sequencer;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       morse;
    logic       err;
    logic [6:0] sel;
  } exp_t;

`ifdef MORSE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Character lookup contents shared by both instances
  logic [4:0]  len_tab [128];
  logic [20:0] pat_tab [128];
  bit          done    [2];

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      len_tab[i] = 5'($urandom_range(0, 23));
      pat_tab[i] = 21'($urandom);
    end
    len_tab[7'h45] = 5'd3;  pat_tab[7'h45] = 21'b100;
    len_tab[7'h54] = 5'd5;  pat_tab[7'h54] = 21'b11100;
    len_tab[7'h7F] = 5'd0;  pat_tab[7'h7F] = 21'h1FFFFF;
    len_tab[7'h20] = 5'd3;  pat_tab[7'h20] = 21'b000;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int U = (gi == 0) ? 4 : 1;
    localparam int G = (gi == 0) ? 2 : 0;

    logic        rst_n, char_valid, char_ready, morse_out, busy;
    logic [6:0]  char_in, lut_sel;
    logic [4:0]  lut_len;
    logic [20:0] lut_pattern;
`ifdef MORSE_ERR_EN
    logic        char_err;
`endif

    exp_t       q[$];
    logic [6:0] cur_sel;
    bit         pend_err;
    int         err_model;

    assign lut_len     = len_tab[lut_sel];
    assign lut_pattern = pat_tab[lut_sel];

    morse_tx_sequencer #(.UNIT_CYCLES(U), .GAP_UNITS(G)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .lut_sel    (lut_sel),
      .lut_len    (lut_len),
      .lut_pattern(lut_pattern),
      .morse_out  (morse_out),
      .busy       (busy)
`ifdef MORSE_ERR_EN
      ,
      .char_err   (char_err)
`endif
    );

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic push(input bit rdy, input bit bsy, input bit m, input bit e,
                        input logic [6:0] s);
      exp_t x;
      x.ready = rdy;
      x.busy  = bsy;
      x.morse = m;
      x.err   = e;
      x.sel   = s;
      q.push_back(x);
    endtask

    task automatic push_idle();
      push(1'b1, 1'b0, 1'b0, pend_err, cur_sel);
      pend_err = 1'b0;
    endtask

    task automatic idle_cycle();
      step();
      char_valid = 1'b0;
      char_in    = 7'($urandom);
      push_idle();
    endtask

    // Offer character c; abort_at >= 0 pulls reset low in that post-acceptance cycle
    task automatic send(input logic [6:0] c, input int abort_at);
      int lc;
      bit bits[$];
      lc = (len_tab[c] > 5'd21) ? 21 : int'(len_tab[c]);
      for (int i = lc - 1; i >= 0; i--)
        for (int k = 0; k < U; k++) bits.push_back(pat_tab[c][i]);
      if (lc > 0)
        for (int k = 0; k < G * U; k++) bits.push_back(1'b0);
      step();
      char_valid = 1'b1;
      char_in    = c;
      push_idle();
      cur_sel = c;
      for (int n = 0; n < 1 + bits.size(); n++) begin
        bit m;
        step();
        char_valid = 1'($urandom);
        char_in    = 7'($urandom);
        m = 1'b0;
        if (n > 0) m = bits[n-1];
        if (n == abort_at) rst_n = 1'b0;
        push(1'b0, 1'b1, m, 1'b0, c);
        if (n == abort_at) begin
          step();
          rst_n      = 1'b1;
          char_valid = 1'b0;
          cur_sel    = 7'h00;
          pend_err   = 1'b0;
          err_model  = 0;
          push_idle();
          return;
        end
      end
      if (lc == 0) begin
        pend_err = ERR_EN;
        if (err_model < 31) err_model++;
      end
    endtask

    initial begin
      rst_n      = 1'b0;
      char_valid = 1'b0;
      char_in    = 7'h00;
      cur_sel    = 7'h00;
      pend_err   = 1'b0;
      err_model  = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_idle();
      send(7'h45, -1);
      idle_cycle();
      send(7'h54, -1);
      idle_cycle();
      send(7'h7F, -1);
      idle_cycle();
`ifdef MORSE_ERR_EN
      chk("err_count_after_7F", gi, 32'(dut.err_count_q), 32'(err_model));
`endif
      send(7'h45, -1);
      send(7'h54, -1);
      send(7'h54, 1 + 2 * U);
      send(7'h20, -1);
      for (int i = 0; i < 40; i++) begin
        int gaps, ab;
        gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) idle_cycle();
        ab = -1;
        if ($urandom_range(0, 9) == 0) ab = int'($urandom_range(0, 6));
        send(7'($urandom), ab);
      end
      idle_cycle();
      idle_cycle();
`ifdef MORSE_ERR_EN
      chk("err_count_final", gi, 32'(dut.err_count_q), 32'(err_model));
`endif
      repeat (3) @(posedge clk);
      done[gi] = 1'b1;
    end

    // Compare the DUT against the oldest pending expectation each cycle
    always @(negedge clk) begin
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        chk("char_ready", gi, 32'(char_ready), 32'(x.ready));
        chk("busy",       gi, 32'(busy),       32'(x.busy));
        chk("morse_out",  gi, 32'(morse_out),  32'(x.morse));
        chk("lut_sel",    gi, 32'(lut_sel),    32'(x.sel));
`ifdef MORSE_ERR_EN
        chk("char_err",   gi, 32'(char_err),   32'(x.err));
`endif
      end
    end
  end

  initial begin
    for (int c = 0; c < 90000 && !(done[0] && done[1]); c++) @(posedge clk);
    if (!(done[0] && done[1])) begin
      checks++;
      errors++;
      $display("FAIL timeout: got done=%0b%0b expected 11", done[1], done[0]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
